// File: rtl/pe_accum_fixed_multi.sv
// Multi-channel saturating fixed-point accumulator with shift/narrow on flush.
// Optional round-half-up at flush is enabled by defining PE_ACCUM_ROUND_EN.
module pe_accum_fixed_multi #(
  parameter int NUM_CHANNELS = 4,
  parameter int DOT_WIDTH    = 16,
  parameter int ACCUM_WIDTH  = 32,
  parameter int RESULT_WIDTH = 16,
  parameter int SHIFT        = 8,
  parameter int IN_DELAY     = 2,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_valid,
  input  logic [CH_W-1:0]                i_channel,
  input  logic signed [DOT_WIDTH-1:0]    i_dot_output,
  input  logic                           i_flush,
  input  logic [CH_W-1:0]                i_flush_channel,
  output logic                           o_valid,
  output logic [CH_W-1:0]                o_channel,
  output logic signed [RESULT_WIDTH-1:0] o_result,
  output logic                           o_saturated
);

  localparam int AW = ACCUM_WIDTH;
  localparam int RW = RESULT_WIDTH;

  if (NUM_CHANNELS < 1 || DOT_WIDTH < 1 || ACCUM_WIDTH < DOT_WIDTH ||
      SHIFT < 0 || SHIFT >= ACCUM_WIDTH || RESULT_WIDTH < 2 ||
      RESULT_WIDTH > ACCUM_WIDTH - SHIFT || IN_DELAY < 0) begin : g_bad_params
    $fatal(1, "pe_accum_fixed_multi: illegal parameter combination");
  end

  localparam logic signed [AW:0]   WIDE_MAX = {{(AW-RW+2){1'b0}}, {(RW-1){1'b1}}};
  localparam logic signed [AW:0]   WIDE_MIN = {{(AW-RW+2){1'b1}}, {(RW-1){1'b0}}};
  localparam logic signed [RW-1:0] RES_MAX  = {1'b0, {(RW-1){1'b1}}};
  localparam logic signed [RW-1:0] RES_MIN  = {1'b1, {(RW-1){1'b0}}};
`ifdef PE_ACCUM_ROUND_EN
  localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [AW:0] ROUND_HALF = (SHIFT > 0) ? ((AW+1)'(1) << HALF_SH) : '0;
`endif

  // Widened by one bit so the rounding offset can never wrap.
  function automatic logic signed [AW:0] scale(input logic signed [AW-1:0] x);
    logic signed [AW:0] w;
    w = {x[AW-1], x};
`ifdef PE_ACCUM_ROUND_EN
    w = w + ROUND_HALF;
`endif
    return w >>> SHIFT;
  endfunction

  function automatic logic out_of_range(input logic signed [AW:0] v);
    return (v > WIDE_MAX) || (v < WIDE_MIN);
  endfunction

  function automatic logic signed [RW-1:0] clamp(input logic signed [AW:0] v);
    if (v > WIDE_MAX) return RES_MAX;
    if (v < WIDE_MIN) return RES_MIN;
    return v[RW-1:0];
  endfunction

  // Stage p0: controls aligned to the incoming dot-product
  logic            vld_p0, fls_p0;
  logic [CH_W-1:0] sch_p0, fch_p0;

  if (IN_DELAY == 0) begin : g_nodly
    assign vld_p0 = i_valid;
    assign fls_p0 = i_flush;
    assign sch_p0 = i_channel;
    assign fch_p0 = i_flush_channel;
  end else begin : g_dly
    logic [IN_DELAY-1:0] vld_sr, fls_sr;
    logic [CH_W-1:0]     sch_sr [IN_DELAY];
    logic [CH_W-1:0]     fch_sr [IN_DELAY];

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_sr <= '0;
        fls_sr <= '0;
      end else begin
        vld_sr[0] <= i_valid;
        fls_sr[0] <= i_flush;
        for (int k = 1; k < IN_DELAY; k++) begin
          vld_sr[k] <= vld_sr[k-1];
          fls_sr[k] <= fls_sr[k-1];
        end
      end
    end

    always_ff @(posedge clock) begin
      sch_sr[0] <= i_channel;
      fch_sr[0] <= i_flush_channel;
      for (int k = 1; k < IN_DELAY; k++) begin
        sch_sr[k] <= sch_sr[k-1];
        fch_sr[k] <= fch_sr[k-1];
      end
    end

    assign vld_p0 = vld_sr[IN_DELAY-1];
    assign fls_p0 = fls_sr[IN_DELAY-1];
    assign sch_p0 = sch_sr[IN_DELAY-1];
    assign fch_p0 = fch_sr[IN_DELAY-1];
  end

  logic signed [AW-1:0]    accum [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pos_sat, neg_sat;

  logic signed [AW-1:0] s_acc, f_acc, fin_acc;
  logic signed [AW:0]   s_sum, scaled;
  logic                 s_hit, s_pos, s_neg, s_ovf, s_unf, s_pos_n, s_neg_n;
  logic                 f_hit, f_pos, f_neg, fin_pos, fin_neg, same_ch;
  logic signed [RW-1:0] res;
  logic                 res_sat;

  // Channel selection by compare so out-of-range codes never alias a channel.
  always_comb begin
    s_acc = '0;
    s_pos = 1'b0;
    s_neg = 1'b0;
    s_hit = 1'b0;
    f_acc = '0;
    f_pos = 1'b0;
    f_neg = 1'b0;
    f_hit = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (sch_p0 == CH_W'(i)) begin
        s_acc = accum[i];
        s_pos = pos_sat[i];
        s_neg = neg_sat[i];
        s_hit = vld_p0;
      end
      if (fch_p0 == CH_W'(i)) begin
        f_acc = accum[i];
        f_pos = pos_sat[i];
        f_neg = neg_sat[i];
        f_hit = fls_p0;
      end
    end
  end

  always_comb begin
    s_sum   = {s_acc[AW-1], s_acc} +
              {{(AW+1-DOT_WIDTH){i_dot_output[DOT_WIDTH-1]}}, i_dot_output};
    s_ovf   = ~s_sum[AW] &  s_sum[AW-1];
    s_unf   =  s_sum[AW] & ~s_sum[AW-1];
    s_pos_n = s_pos | (s_ovf & ~s_neg);
    s_neg_n = s_neg | (s_unf & ~s_pos);
    same_ch = s_hit && (sch_p0 == fch_p0);
    fin_acc = same_ch ? s_sum[AW-1:0] : f_acc;
    fin_pos = same_ch ? s_pos_n : f_pos;
    fin_neg = same_ch ? s_neg_n : f_neg;
    scaled  = scale(fin_acc);
    if (fin_pos) begin
      res     = RES_MAX;
      res_sat = 1'b1;
    end else if (fin_neg) begin
      res     = RES_MIN;
      res_sat = 1'b1;
    end else begin
      res     = clamp(scaled);
      res_sat = out_of_range(scaled);
    end
  end

  // Flush clears a channel even when it also receives the same-cycle sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) accum[i] <= '0;
      pos_sat <= '0;
      neg_sat <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (f_hit && fch_p0 == CH_W'(i)) begin
          accum[i]   <= '0;
          pos_sat[i] <= 1'b0;
          neg_sat[i] <= 1'b0;
        end else if (s_hit && sch_p0 == CH_W'(i)) begin
          accum[i]   <= s_sum[AW-1:0];
          pos_sat[i] <= s_pos_n;
          neg_sat[i] <= s_neg_n;
        end
      end
    end
  end

  // Stage p1: registered result, held between pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      o_valid     <= 1'b0;
      o_channel   <= '0;
      o_result    <= '0;
      o_saturated <= 1'b0;
    end else begin
      o_valid <= f_hit;
      if (f_hit) begin
        o_channel   <= fch_p0;
        o_result    <= res;
        o_saturated <= res_sat;
      end
    end
  end

endmodule

// File: tb/tb_pe_accum_fixed_multi.sv
// Scoreboard bench for pe_accum_fixed_multi: a default instance and a
// narrow-accumulator instance (ACCUM_WIDTH=20, five channels) share stimulus wires.
module tb_pe_accum_fixed_multi;

`ifdef PE_ACCUM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int D = 2;

  typedef struct {
    int cyc;
    int ch;
    int res;
    bit sat;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic va, vb, fa, fb;
  logic [2:0] ch_in, fch_in;
  logic signed [15:0] dot_in;

  logic               o_valid_a, o_saturated_a, o_valid_b, o_saturated_b;
  logic [1:0]         o_channel_a;
  logic [2:0]         o_channel_b;
  logic signed [15:0] o_result_a, o_result_b;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [15:0] hist[$];

  pe_accum_fixed_multi dut_a (
    .clock(clock), .reset(reset),
    .i_valid(va), .i_channel(ch_in[1:0]), .i_dot_output(dot_in),
    .i_flush(fa), .i_flush_channel(fch_in[1:0]),
    .o_valid(o_valid_a), .o_channel(o_channel_a),
    .o_result(o_result_a), .o_saturated(o_saturated_a)
  );

  pe_accum_fixed_multi #(
    .NUM_CHANNELS(5), .DOT_WIDTH(16), .ACCUM_WIDTH(20),
    .RESULT_WIDTH(16), .SHIFT(4), .IN_DELAY(D)
  ) dut_b (
    .clock(clock), .reset(reset),
    .i_valid(vb), .i_channel(ch_in), .i_dot_output(dot_in),
    .i_flush(fb), .i_flush_channel(fch_in),
    .o_valid(o_valid_b), .o_channel(o_channel_b),
    .o_result(o_result_b), .o_saturated(o_saturated_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (o_valid_a) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL a_spurious: o_valid=1 ch=%0d res=%0d at cycle %0d, required no pulse",
                 o_channel_a, o_result_a, cyc);
      end else begin
        ea = qa.pop_front();
        if (cyc != ea.cyc || int'(o_channel_a) != ea.ch ||
            int'(o_result_a) != ea.res || o_saturated_a != ea.sat) begin
          n_err++;
          $display("FAIL a_result: got cyc=%0d ch=%0d res=%0d sat=%0d, required cyc=%0d ch=%0d res=%0d sat=%0d",
                   cyc, o_channel_a, o_result_a, o_saturated_a, ea.cyc, ea.ch, ea.res, ea.sat);
        end
      end
    end else if (qa.size() > 0 && qa[0].cyc <= cyc) begin
      n_cmp++;
      n_err++;
      ea = qa.pop_front();
      $display("FAIL a_missing: no o_valid at cycle %0d, required ch=%0d res=%0d sat=%0d",
               cyc, ea.ch, ea.res, ea.sat);
    end
  end

  always @(negedge clock) begin
    if (o_valid_b) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL b_spurious: o_valid=1 ch=%0d res=%0d at cycle %0d, required no pulse",
                 o_channel_b, o_result_b, cyc);
      end else begin
        eb = qb.pop_front();
        if (cyc != eb.cyc || int'(o_channel_b) != eb.ch ||
            int'(o_result_b) != eb.res || o_saturated_b != eb.sat) begin
          n_err++;
          $display("FAIL b_result: got cyc=%0d ch=%0d res=%0d sat=%0d, required cyc=%0d ch=%0d res=%0d sat=%0d",
                   cyc, o_channel_b, o_result_b, o_saturated_b, eb.cyc, eb.ch, eb.res, eb.sat);
        end
      end
    end else if (qb.size() > 0 && qb[0].cyc <= cyc) begin
      n_cmp++;
      n_err++;
      eb = qb.pop_front();
      $display("FAIL b_missing: no o_valid at cycle %0d, required ch=%0d res=%0d sat=%0d",
               cyc, eb.ch, eb.res, eb.sat);
    end
  end

  // The dot value of a sample is presented D cycles after its valid/channel.
  task automatic drive(input bit a_v, input bit b_v, input int ch, input int dot,
                       input bit a_f, input bit b_f, input int fch);
    va     = a_v;
    vb     = b_v;
    fa     = a_f;
    fb     = b_f;
    ch_in  = 3'(ch);
    fch_in = 3'(fch);
    hist.push_back(16'(dot));
    if (hist.size() > D) dot_in = hist.pop_front();
    else dot_in = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic samples_a(input int ch, input int dot, input int n);
    repeat (n) drive(1, 0, ch, dot, 0, 0, 0);
  endtask

  task automatic samples_b(input int ch, input int dot, input int n);
    repeat (n) drive(0, 1, ch, dot, 0, 0, 0);
  endtask

  task automatic push_a(input int ch, input int res, input bit sat);
    qa.push_back('{cyc + D + 1, ch, res, sat});
  endtask

  task automatic push_b(input int ch, input int res, input bit sat);
    qb.push_back('{cyc + D + 1, ch, res, sat});
  endtask

  task automatic flush_a(input int ch, input int res, input bit sat);
    push_a(ch, res, sat);
    drive(0, 0, 0, 0, 1, 0, ch);
  endtask

  task automatic flush_b(input int ch, input int res, input bit sat);
    push_b(ch, res, sat);
    drive(0, 0, 0, 0, 0, 1, ch);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    chk("a_reset_valid", int'(o_valid_a), 0);
    chk("a_reset_result", int'(o_result_a), 0);
    chk("a_reset_channel", int'(o_channel_a), 0);
    chk("a_reset_sat", int'(o_saturated_a), 0);
    chk("b_reset_valid", int'(o_valid_b), 0);
    chk("b_reset_result", int'(o_result_b), 0);
    chk("b_reset_channel", int'(o_channel_b), 0);
    chk("b_reset_sat", int'(o_saturated_b), 0);

    // ch0: 4 samples, then flush together with a fifth: 1280>>>8 = 5
    samples_a(0, 'h100, 4);
    push_a(0, 5, 0);
    drive(1, 0, 0, 'h100, 1, 0, 0);
    flush_a(0, 0, 0);
    idle(4);

    // Interleaved ch1 +900 and ch2 -900, consecutive flushes
    repeat (3) begin
      drive(1, 0, 1, 300, 0, 0, 0);
      drive(1, 0, 2, -300, 0, 0, 0);
    end
    flush_a(1, RND ? 4 : 3, 0);
    flush_a(2, -4, 0);
    idle(5);
    chk("a_hold_result", int'(o_result_a), -4);
    chk("a_hold_channel", int'(o_channel_a), 2);

    // Narrowing clamp: 257*32767 >>> 8 = 32894 > 32767
    samples_a(0, 'h7FFF, 257);
    flush_a(0, 32767, 1);
    // Negative narrowing clamp: 257*-32768 >>> 8 = -32896 < -32768
    samples_a(3, -32768, 257);
    flush_a(3, -32768, 1);

    // Rounding: +0x180 with same-cycle flush, then -0x180
    push_a(1, RND ? 2 : 1, 0);
    drive(1, 0, 1, 'h180, 1, 0, 1);
    samples_a(2, -'h180, 1);
    flush_a(2, RND ? -1 : -2, 0);
    idle(4);

    // Narrow instance: plain value 768 >>> 4 = 48
    samples_b(0, 'h100, 3);
    flush_b(0, 48, 0);
    // Sticky positive saturation: overflow then heavy negative accumulation
    samples_b(3, 'h7FFF, 17);
    samples_b(3, -'h7FFF, 20);
    flush_b(3, 32767, 1);
    // Sticky negative saturation
    samples_b(0, -32768, 17);
    samples_b(0, 'h7FFF, 20);
    flush_b(0, -32768, 1);
    // Out-of-range channel 5: sample dropped, flush ignored
    samples_b(5, 'h100, 1);
    drive(0, 0, 0, 0, 0, 1, 5);
    flush_b(1, 0, 0);
    idle(5);

    // Reset with ch0 holding 0x500 and a flush in the delay line
    samples_a(0, 'h500, 1);
    idle(3);
    drive(0, 0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("a_rst2_result", int'(o_result_a), 0);
    chk("a_rst2_sat", int'(o_saturated_a), 0);
    idle(4);
    flush_a(0, 0, 0);
    idle(6);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
